// File: rtl/bmux_arb.sv
// Registered N-way bus multiplexer with valid/ready handshake.
// Channels are chosen by direct select (MODE 0) or by round-robin among valid inputs (MODE 1).
module bmux_arb #(
   parameter int WIDTH = 16,
   parameter int N     = 4,
   parameter int SELW  = 2,
   parameter int MODE  = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [SELW-1:0]      s,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     r,
   output logic                 r_valid,
   input  logic                 r_ready,
   output logic [SELW-1:0]      r_src
);

   logic [SELW-1:0]  rr_ptr;
   logic [N-1:0]     grant;
   logic             gnt_any;
   logic [SELW-1:0]  gnt_idx;
   logic [WIDTH-1:0] gnt_data;
   logic [SELW-1:0]  ptr_nxt;
   logic             load;
   logic             xfer;

   // Select stage: one-hot grant plus the granted index and data word
   always_comb begin
      int idx;
      idx      = 0;
      grant    = '0;
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      gnt_data = '0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (s == SELW'(i) && in_valid[i]) begin
               grant[i] = 1'b1;
               gnt_any  = 1'b1;
               gnt_idx  = SELW'(i);
               gnt_data = in_data[i*WIDTH +: WIDTH];
            end
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && in_valid[idx]) begin
               grant[idx] = 1'b1;
               gnt_any    = 1'b1;
               gnt_idx    = SELW'(idx);
               gnt_data   = in_data[idx*WIDTH +: WIDTH];
            end
         end
      end
   end

   assign load     = !r_valid || r_ready;
   assign xfer     = load && gnt_any;
   // Ready is forced low while reset is asserted, even though load would be 1
   assign in_ready = (reset_n && load) ? grant : '0;
   assign ptr_nxt  = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + SELW'(1);

   // Output stage: one-entry register, refilled in the same edge it drains
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r       <= '0;
         r_valid <= 1'b0;
         r_src   <= '0;
         rr_ptr  <= '0;
      end else if (load) begin
         if (xfer) begin
            r       <= gnt_data;
            r_src   <= gnt_idx;
            r_valid <= 1'b1;
            if (MODE == 1) rr_ptr <= ptr_nxt;
         end else begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule
